// File: rtl/i2s_frame_receiver.sv
// i2s_frame_receiver: oversampled serial receiver packing MSB-first words into a circular frame buffer.
// Define I2S_RX_ABORT_CNT_EN to add the saturating aborted_frames_o counter.
module i2s_frame_receiver #(
  parameter int OVERSAMPLE = 4,
  parameter int SAMPLE_PHASE = 2,
  parameter int FRAME_BITS = 256,
  parameter int WORD_BITS = 8,
  parameter int CIRC_BUF_BITS = 3,
  parameter int ADDR_W = CIRC_BUF_BITS + $clog2(FRAME_BITS / WORD_BITS)
) (
  input  logic                     clk_x4_i,
  input  logic                     rst_i,
  input  logic                     i2s_running_i,
  input  logic                     i2s_data_i,
  output logic [ADDR_W-1:0]        ram_write_addr_o,
  output logic                     ram_write_en_o,
  output logic [WORD_BITS-1:0]     ram_write_data_o,
  output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
  output logic                     frame_valid_o,
`ifdef I2S_RX_ABORT_CNT_EN
  output logic [7:0]               aborted_frames_o,
`endif
  output logic                     frame_done_o
);
  localparam int WPF = FRAME_BITS / WORD_BITS;
  localparam int WIW = WPF > 1 ? $clog2(WPF) : 1;
  localparam int BW = WORD_BITS > 1 ? $clog2(WORD_BITS) : 1;
  localparam int PW = $clog2(OVERSAMPLE);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [PW-1:0] phase;
  logic [BW-1:0] bit_cnt;
  logic [WIW-1:0] word_idx;
  logic [CIRC_BUF_BITS-1:0] frame_idx;
  logic [WORD_BITS-1:0] shift_q, shift_n;
  logic [ADDR_W-1:0] addr;
  logic sample, word_full, last_word, abort;
  always_ff @(posedge clk_x4_i)
    state <= rst_i ? IDLE : state_n;
  // Phase is held at 0 while idle, so the first high cycle is phase 0 of bit 0.
  always_comb begin
    state_n = i2s_running_i ? RUN : IDLE;
    sample = i2s_running_i && phase == PW'(SAMPLE_PHASE);
    word_full = sample && bit_cnt == BW'(WORD_BITS - 1);
    last_word = word_idx == WIW'(WPF - 1);
    abort = state == RUN && !i2s_running_i && !frame_done_o;
    shift_n = (shift_q << 1) | WORD_BITS'(i2s_data_i);
    addr = ADDR_W'(frame_idx) * ADDR_W'(WPF) + ADDR_W'(word_idx);
  end
  // Write strobe and frame_done mark the completion cycle; indices advance at its end.
  always_ff @(posedge clk_x4_i) begin
    if (rst_i) begin
      ram_write_addr_o <= '0;
      ram_write_en_o <= 1'b0;
      ram_write_data_o <= '0;
      last_good_frame_idx_o <= '0;
      frame_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      phase <= '0;
      bit_cnt <= '0;
      word_idx <= '0;
      frame_idx <= '0;
      shift_q <= '0;
    end else begin
      ram_write_en_o <= word_full;
      frame_done_o <= word_full && last_word;
      if (word_full) begin
        ram_write_data_o <= shift_n;
        ram_write_addr_o <= addr;
      end
      phase <= !i2s_running_i || phase == PW'(OVERSAMPLE - 1) ? '0 : phase + 1'b1;
      bit_cnt <= !i2s_running_i || word_full ? '0 : bit_cnt + BW'(sample);
      shift_q <= !i2s_running_i ? '0 : sample ? shift_n : shift_q;
      word_idx <= abort || frame_done_o ? '0 : word_idx + WIW'(ram_write_en_o);
      if (frame_done_o) begin
        last_good_frame_idx_o <= frame_idx;
        frame_valid_o <= 1'b1;
        frame_idx <= frame_idx + 1'b1;
      end
    end
  end
`ifdef I2S_RX_ABORT_CNT_EN
  always_ff @(posedge clk_x4_i)
    aborted_frames_o <= rst_i ? 8'd0 : abort && aborted_frames_o != 8'hFF ? aborted_frames_o + 8'd1 : aborted_frames_o;
`endif
endmodule
